alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A granted operation
//   is captured in IDLE, presented to the ALU for exactly one cycle in EXEC,
//   and its result is held in RESP until the consumer takes it. There is one
//   operation in flight at a time, so the best case is one operation every
//   3 cycles.
//
// Parameters
//   RR_EN       1: round-robin between the requesters on a tie,
//               0: requester 0 always wins a tie.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid/ready        requester handshake (N = 0, 1)
//   reqN_op, reqN_a/b       opcode (0 nop,1 add,2 sub,3 and,4 or,5 slt,
//                           6 sll,7 lui; 8..15 illegal) and operands
//   alu_op, alu_a, alu_b    operation to the shared ALU (zero unless EXEC)
//   alu_c                   combinational ALU result
//   rsp_valid/ready         response handshake
//   rsp_data, rsp_id        captured result and issuing requester
//   rsp_err                 issued opcode was illegal (rsp_data forced to 0)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;       // requester granted most recently
  logic [3:0]  op_q, op_d;           // already mapped to nop if illegal
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant1;
  logic        accept_idle;
  logic [3:0]  sel_op;

  // ---------------------------------------------------------------------------
  // Grant. rst_n gates ready so nothing is offered while reset is held, even
  // though the state register already sits in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    grant1      = 1'b0;
    accept_idle = (state_q == IDLE) && rst_n;
    if (req0_valid && req1_valid) begin
      // On a tie, round-robin favours whoever did not win last time.
      grant1 = RR_EN ? ~last_q : 1'b0;
    end else begin
      grant1 = req1_valid;
    end
    req0_ready = accept_idle && req0_valid && !grant1;
    req1_ready = accept_idle && req1_valid && grant1;
  end

  // ---------------------------------------------------------------------------
  // Next state, capture and ALU drive.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    alu_op      = 4'd0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    sel_op      = req1_ready ? req1_op : req0_op;

    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = EXEC;
          last_d  = req1_ready;
          id_d    = req1_ready;
          // Illegal opcodes run as a nop; the error bit remembers why.
          err_d   = sel_op[3];
          op_d    = sel_op[3] ? 4'd0 : sel_op;
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? req1_b : req0_b;
        end
      end
      EXEC: begin
        alu_op      = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = err_q ? 32'd0 : alu_c;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. The last-grant pointer resets to 1 so requester 0 wins
  // the first tie after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and response registers are reset as well, because the
      // response outputs are read directly from them and must read 0 in reset.
      state_q     <= IDLE;
      last_q      <= 1'b1;
      op_q        <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A round-robin instance is checked
//   every cycle against a transaction-level model (one outstanding operation,
//   its age in edges, and the last winner); directed sequences pin the model
//   with literal values. A second, fixed-priority instance gets a short tie
//   test of its own.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  // ---------------------------------------------------------------- results
  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a << b[4:0];
      4'd7:    return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  // An ALU fed an undefined opcode may return anything.
  function automatic logic [31:0] env_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    return (op > 4'd7) ? 32'hDEAD_BEEF : ref_alu(op, a, b);
  endfunction

  // ---------------------------------------------------------------- signals
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_c;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  logic        fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
  logic [3:0]  fp_alu_op;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_c, fp_rsp_data;
  logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_err;

  always #5 clk = ~clk;

  assign alu_c    = env_alu(alu_op, alu_a, alu_b);
  assign fp_alu_c = env_alu(fp_alu_op, fp_alu_a, fp_alu_b);

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(4'd1),
    .req0_a(32'd1), .req0_b(32'd1),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(4'd2),
    .req1_a(32'd9), .req1_b(32'd4),
    .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_c(fp_alu_c),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_data(fp_rsp_data),
    .rsp_id(fp_rsp_id), .rsp_err(fp_rsp_err)
  );

  // ---------------------------------------------------------------- model
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          m_busy;          // an operation is outstanding
  int          m_age;           // edges since its acceptance
  bit          m_id, m_last;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  bit          e_rdy0, e_rdy1, e_rv, hs0, hs1;
  int          grant_log[$];
  logic [31:0] rsp_log[$];
  int          rid_log[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Checks every output of the round-robin instance against the model.
  task automatic compare();
    int          winner;
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    e_rdy0 = 1'b0;
    e_rdy1 = 1'b0;
    if (rst_n && !m_busy && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) winner = m_last ? 0 : 1;
      else                          winner = req1_valid ? 1 : 0;
      e_rdy0 = (winner == 0);
      e_rdy1 = (winner == 1);
    end
    e_rv = m_busy && (m_age >= 2);
    eop = 4'd0; ea = 32'd0; eb = 32'd0;
    if (m_busy && m_age == 1) begin
      eop = (m_op > 4'd7) ? 4'd0 : m_op;
      ea  = m_a;
      eb  = m_b;
    end
    chk("req0_ready", req0_ready, e_rdy0);
    chk("req1_ready", req1_ready, e_rdy1);
    chk("alu_op", alu_op, eop);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      chk("rsp_data", rsp_data, (m_op > 4'd7) ? 32'd0 : ref_alu(m_op, m_a, m_b));
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_err", rsp_err, m_op > 4'd7);
    end
    if (!rst_n) begin
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
    end
    if (req0_valid && req0_ready) grant_log.push_back(0);
    if (req1_valid && req1_ready) grant_log.push_back(1);
    if (rsp_valid && rsp_ready) begin
      rsp_log.push_back(rsp_data);
      rid_log.push_back(int'(rsp_id));
    end
  endtask

  // One clock: check, advance the model over the rising edge, return at the
  // following falling edge where new stimulus is applied.
  task automatic tick();
    bit rhs;
    #1;
    compare();
    hs0 = e_rdy0 && req0_valid;
    hs1 = e_rdy1 && req1_valid;
    rhs = e_rv && rsp_ready;
    @(posedge clk);
    if (rst_n) begin
      if (rhs) m_busy = 1'b0;
      else if (m_busy) m_age++;
      if (hs0 || hs1) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = hs1;
        m_last = hs1;
        m_op   = hs1 ? req1_op : req0_op;
        m_a    = hs1 ? req1_a : req0_a;
        m_b    = hs1 ? req1_b : req0_b;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (3) tick();
  endtask

  task automatic set_req(input int id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Single operation from an idle block, with literal expectations.
  task automatic run_one(input string name, input int id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_alu_op,
                         input logic [31:0] exp_data, input logic exp_err);
    rsp_ready = 1'b1;
    set_req(id, op, a, b);
    tick();                                   // acceptance edge
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 chk({name, "_exec_alu_op"}, alu_op, exp_alu_op);
    tick();                                   // second edge: response
    #1 chk({name, "_rsp_valid"}, rsp_valid, 1);
    chk({name, "_rsp_data"}, rsp_data, exp_data);
    chk({name, "_rsp_id"}, rsp_id, id);
    chk({name, "_rsp_err"}, rsp_err, exp_err);
    tick();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int fp_grants, fp_rsps;
    rst_n = 1'b0;
    {req0_valid, req1_valid, rsp_ready} = '0;
    {req0_op, req1_op} = '0;
    {req0_a, req0_b, req1_a, req1_b} = '0;
    {fp_req0_valid, fp_req1_valid, fp_rsp_ready} = '0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_op", alu_op, 0);
    rst_n = 1'b1;

    // Single add, then both requesters tied continuously.
    run_one("add", 0, 4'd1, 32'd5, 32'd7, 4'd1, 32'd12, 1'b0);
    rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
    grant_log.delete(); rsp_log.delete(); rid_log.delete();
    rsp_ready = 1'b1;
    set_req(0, 4'd1, 32'd1, 32'd1);
    set_req(1, 4'd2, 32'd9, 32'd4);
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      chk("tie_grant", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
      chk("tie_rsp", (i < rsp_log.size()) ? rsp_log[i] : 32'hFFFF_FFFF,
          (i % 2 == 0) ? 32'd2 : 32'd5);
      chk("tie_rsp_id", (i < rid_log.size()) ? rid_log[i] : -1, i % 2);
    end
    drain();

    // Backpressure: response held while req1 waits.
    rsp_ready = 1'b0;
    set_req(0, 4'd5, 32'hFFFF_FFFF, 32'd1);
    tick();
    req0_valid = 1'b0;
    set_req(1, 4'd1, 32'd2, 32'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_rsp_data", rsp_data, 1);
      chk("bp_req1_ready", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1 chk("bp_req1_granted", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    drain();

    // Illegal opcode and shifts.
    run_one("illegal", 1, 4'hA, 32'd3, 32'd4, 4'd0, 32'd0, 1'b1);
    run_one("sll", 0, 4'd6, 32'd1, 32'h24, 4'd6, 32'h10, 1'b0);
    run_one("lui", 0, 4'd7, 32'd0, 32'h1234, 4'd7, 32'h1234_0000, 1'b0);

    // Reset during EXEC discards the operation; next tie goes to requester 0.
    set_req(0, 4'd1, 32'd2, 32'd3);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    set_req(0, 4'd3, 32'hF0, 32'h3C);
    set_req(1, 4'd4, 32'hF0, 32'h0F);
    #1 chk("midrst_req0_ready", req0_ready, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("postrst_req0_ready", req0_ready, 1);
    chk("postrst_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    #1 chk("postrst_rsp_data", rsp_data, 32'h30);
    drain();

    // Randomised traffic checked by the model every cycle.
    for (int n = 0; n < 1500; n++) begin
      if (!req0_valid) begin
        if ($urandom_range(0, 9) < 4)
          set_req(0, 4'($urandom_range(0, 11)), rand_operand(), rand_operand());
      end else if (!m_busy && $urandom_range(0, 19) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid) begin
        if ($urandom_range(0, 9) < 4)
          set_req(1, 4'($urandom_range(0, 11)), rand_operand(), rand_operand());
      end else if (!m_busy && $urandom_range(0, 19) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
    end
    drain();

    // Fixed priority: only requester 0 is ever granted on a tie.
    fp_grants = 0;
    fp_rsps   = 0;
    fp_req0_valid = 1'b1;
    fp_req1_valid = 1'b1;
    fp_rsp_ready  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1 chk("fp_req1_ready", fp_req1_ready, 0);
      if (fp_req0_valid && fp_req0_ready) fp_grants++;
      if (fp_rsp_valid && fp_rsp_ready) begin
        fp_rsps++;
        chk("fp_rsp_id", fp_rsp_id, 0);
        chk("fp_rsp_data", fp_rsp_data, 2);
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("fp_grants", fp_grants, 4);
    chk("fp_rsps", fp_rsps, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
